// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/mosi/ce on the system clock, deserialises
// mosi into rx words and serialises a one-deep tx buffer onto miso, MSB first.
// Optional feature macro: SPI_SLAVE_UNDERRUN_EN adds the tx_underrun pulse output.
module spi_slave #(
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit CE_LEVEL   = 1'b0,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
`ifdef SPI_SLAVE_UNDERRUN_EN
    output logic                  tx_underrun,
`endif
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  ce
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state, state_next;
    logic [2:0]            sclk_q, ce_q;
    logic [1:0]            mosi_q;
    logic                  sclk_s, sclk_d, mosi_s, ce_act, ce_act_d;
    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic                  ce_rise, load_now, shift_now, sample_now, last_bit, hs;
    logic                  enter, abort;
    logic [DATA_WIDTH-1:0] rx_sr, tx_sr, tx_buf;
    logic                  buf_full, load_pend;
    logic [CW-1:0]         bit_cnt;

    // Pin synchronisers; sclk and ce keep a third history stage for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q <= {3{CPOL}};
            ce_q   <= {3{~CE_LEVEL}};
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ce_q   <= {ce_q[1:0], ce};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_s      = sclk_q[1];
    assign sclk_d      = sclk_q[2];
    assign mosi_s      = mosi_q[1];
    assign ce_act      = (ce_q[1] == CE_LEVEL);
    assign ce_act_d    = (ce_q[2] == CE_LEVEL);
    assign ce_rise     = ce_act & ~ce_act_d;
    assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign hs       = tx_valid & ~buf_full;
    assign tx_ready = ~buf_full;
    assign busy     = (state == SHIFT);
    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign enter    = (state == IDLE) && ce_rise;
    assign abort    = (state == SHIFT) && !ce_act;

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus per-cycle load/shift/sample strobes; ce release masks any edge.
    always_comb begin
        state_next = state;
        load_now   = 1'b0;
        shift_now  = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE: begin
                if (ce_rise) begin
                    state_next = SHIFT;
                    load_now   = ~CPHA;
                end
            end
            SHIFT: begin
                if (!ce_act) begin
                    state_next = IDLE;
                end else begin
                    sample_now = sample_edge;
                    if (shift_edge) begin
                        load_now  = load_pend;
                        shift_now = ~load_pend;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx buffer, shift registers, bit counter and received-word output.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_buf    <= '0;
            buf_full  <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            miso      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // A write into an empty buffer at a load point is kept for the next load.
            if (hs) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end else if (load_now) begin
                buf_full <= 1'b0;
            end

            if (load_now) begin
                tx_sr     <= buf_full ? tx_buf : '0;
                miso      <= buf_full & tx_buf[DATA_WIDTH-1];
                load_pend <= 1'b0;
            end else if (shift_now) begin
                tx_sr <= tx_sr << 1;
                miso  <= tx_sr[DATA_WIDTH-2];
            end

            if (enter) begin
                bit_cnt   <= '0;
                rx_sr     <= '0;
                load_pend <= CPHA;
            end

            if (abort) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
                miso      <= 1'b0;
            end

            if (sample_now) begin
                rx_sr <= (rx_sr << 1) | DATA_WIDTH'(mosi_s);
                if (last_bit) begin
                    rx_data   <= (rx_sr << 1) | DATA_WIDTH'(mosi_s);
                    rx_valid  <= 1'b1;
                    bit_cnt   <= '0;
                    load_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    // Flag every load point that found the buffer empty.
    always_ff @(posedge clock) begin
        if (reset) tx_underrun <= 1'b0;
        else       tx_underrun <= load_now & ~buf_full;
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one DUT per CPOL/CPHA mode, DATA_WIDTH=8, sclk=clock/16.
module tb_spi_slave;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [3:0][7:0] tx_data_v = '0;
    logic [3:0]      tx_valid_v = '0;
    logic [3:0]      sclk_v = 4'b1100;
    logic [3:0]      mosi_v = '0;
    logic [3:0]      ce_v = 4'b1111;
    wire  [3:0]      tx_ready_v, rx_valid_v, busy_v, miso_v;
    wire  [3:0][7:0] rx_data_v;
`ifdef SPI_SLAVE_UNDERRUN_EN
    wire  [3:0]      und_v;
    int              und_cnt [4];
    int              und_snap[4];
`endif

    int        checks = 0;
    int        errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx[4];
    int        rx_cnt[4];
    logic [7:0] e;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : gm
        localparam bit P = (g >= 2);
        localparam bit H = ((g % 2) == 1);
        spi_slave #(.CPOL(P), .CPHA(H), .CE_LEVEL(1'b0), .DATA_WIDTH(8)) u_dut (
            .clock   (clock),
            .reset   (reset),
            .tx_data (tx_data_v[g]),
            .tx_valid(tx_valid_v[g]),
            .tx_ready(tx_ready_v[g]),
            .rx_data (rx_data_v[g]),
            .rx_valid(rx_valid_v[g]),
            .busy    (busy_v[g]),
`ifdef SPI_SLAVE_UNDERRUN_EN
            .tx_underrun(und_v[g]),
`endif
            .sclk    (sclk_v[g]),
            .mosi    (mosi_v[g]),
            .miso    (miso_v[g]),
            .ce      (ce_v[g])
        );
    end

    task automatic chk(input string nm, input int m, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s mode %0d got %h expected %h", nm, m, got, exp);
        end
    endtask

    // Monitor: every rx_valid pulse pops one expected word.
    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
`ifdef SPI_SLAVE_UNDERRUN_EN
            if (und_v[k]) und_cnt[k]++;
`endif
            if (rx_valid_v[k]) begin
                rx_cnt[k]++;
`ifdef SPI_SLAVE_UNDERRUN_EN
                und_snap[k] = und_cnt[k];
`endif
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected mode %0d got %h expected none", k, rx_data_v[k]);
                end else begin
                    e = exp_q.pop_front();
                    last_rx[k] = e;
                    if (rx_data_v[k] !== e) begin
                        errors++;
                        $display("FAIL rx_data mode %0d got %h expected %h", k, rx_data_v[k], e);
                    end
                end
            end
        end
    end

    // Offer one word on the tx port and hold it until accepted (bounded).
    task automatic push(input int m, input logic [7:0] d);
        int n = 0;
        @(negedge clock);
        tx_valid_v[m] = 1'b1;
        tx_data_v[m]  = d;
        while (!tx_ready_v[m] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("tx_handshake", m, 16'(tx_ready_v[m]), 16'd1);
        @(negedge clock);
        tx_valid_v[m] = 1'b0;
    endtask

    // Behave as the SPI master for nbits bits of mo, collecting miso into mi.
    task automatic frame(input int m, input int nbits, input logic [15:0] mo,
                         output logic [15:0] mi, input bit rel);
        logic cpol = 1'((m >> 1) & 1);
        logic cpha = 1'(m & 1);
        mi = '0;
        ce_v[m] = 1'b0;
        if (!cpha) mosi_v[m] = mo[nbits-1];
        repeat (8) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                sclk_v[m] = ~cpol;
                mi = {mi[14:0], miso_v[m]};
                repeat (8) @(negedge clock);
                sclk_v[m] = cpol;
                if (i + 1 < nbits) mosi_v[m] = mo[nbits-2-i];
                repeat (8) @(negedge clock);
            end else begin
                sclk_v[m] = ~cpol;
                mosi_v[m] = mo[nbits-1-i];
                repeat (8) @(negedge clock);
                sclk_v[m] = cpol;
                mi = {mi[14:0], miso_v[m]};
                repeat (8) @(negedge clock);
            end
        end
        if (rel) ce_v[m] = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog mode -1 got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] mi;
        int c0;
        int u0;
        for (int k = 0; k < 4; k++) begin
            last_rx[k] = '0;
            rx_cnt[k]  = 0;
`ifdef SPI_SLAVE_UNDERRUN_EN
            und_cnt[k] = 0;
            und_snap[k] = 0;
`endif
        end
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            chk("rst_tx_ready", k, 16'(tx_ready_v[k]), 16'd1);
            chk("rst_rx_data",  k, 16'(rx_data_v[k]), 16'h0);
            chk("rst_rx_valid", k, 16'(rx_valid_v[k]), 16'd0);
            chk("rst_busy",     k, 16'(busy_v[k]), 16'd0);
            chk("rst_miso",     k, 16'(miso_v[k]), 16'd0);
        end

        for (int m = 0; m < 4; m++) begin
            // Single word exchange.
            c0 = rx_cnt[m];
            push(m, 8'hA5);
            exp_q.push_back(8'h3C);
            frame(m, 8, 16'h003C, mi, 1'b1);
            chk("miso_a5", m, mi, 16'h00A5);
            chk("rx_pulses", m, 16'(rx_cnt[m] - c0), 16'd1);
            chk("rx_hold_3c", m, 16'(rx_data_v[m]), 16'h003C);
            chk("busy_idle", m, 16'(busy_v[m]), 16'd0);

            // Back-to-back words; second tx word waits with tx_valid held on a full buffer.
            push(m, 8'h55);
            fork push(m, 8'hAA); join_none
            repeat (10) @(negedge clock);
            chk("tx_ready_full", m, 16'(tx_ready_v[m]), 16'd0);
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h80);
            frame(m, 16, 16'h0180, mi, 1'b1);
            wait fork;
            chk("miso_55aa", m, mi, 16'h55AA);
            chk("tx_ready_after", m, 16'(tx_ready_v[m]), 16'd1);
            chk("rx_q_empty", m, 16'(exp_q.size()), 16'd0);

            // Underrun: nothing loaded.
`ifdef SPI_SLAVE_UNDERRUN_EN
            u0 = und_cnt[m];
`else
            u0 = 0;
`endif
            exp_q.push_back(8'hFF);
            frame(m, 8, 16'h00FF, mi, 1'b1);
            chk("miso_zero", m, mi, 16'h0000);
`ifdef SPI_SLAVE_UNDERRUN_EN
            chk("underrun_once", m, 16'(und_snap[m] - u0), 16'd1);
`endif

            // ce released after 5 bits: word discarded.
            c0 = rx_cnt[m];
            frame(m, 5, 16'h0018, mi, 1'b1);
            chk("partial_no_rx", m, 16'(rx_cnt[m] - c0), 16'd0);
            chk("partial_rx_keep", m, 16'(rx_data_v[m]), 16'(last_rx[m]));
            chk("partial_busy", m, 16'(busy_v[m]), 16'd0);
            push(m, 8'h96);
            exp_q.push_back(8'h5A);
            frame(m, 8, 16'h005A, mi, 1'b1);
            chk("miso_96", m, mi, 16'h0096);

            // Reset at bit 4 with a word still buffered.
            push(m, 8'hFF);
            frame(m, 4, 16'h0009, mi, 1'b0);
            chk("mid_busy", m, 16'(busy_v[m]), 16'd1);
            chk("mid_miso", m, 16'(miso_v[m]), 16'd1);
            push(m, 8'h77);
            chk("mid_tx_ready", m, 16'(tx_ready_v[m]), 16'd0);
            reset = 1'b1;
            @(negedge clock);
            chk("rr_tx_ready", m, 16'(tx_ready_v[m]), 16'd1);
            chk("rr_busy",     m, 16'(busy_v[m]), 16'd0);
            chk("rr_rx_data",  m, 16'(rx_data_v[m]), 16'h0);
            chk("rr_miso",     m, 16'(miso_v[m]), 16'd0);
            chk("rr_rx_valid", m, 16'(rx_valid_v[m]), 16'd0);
            ce_v[m] = 1'b1;
            for (int k = 0; k < 4; k++) last_rx[k] = '0;
            repeat (4) @(negedge clock);
            reset = 1'b0;
            repeat (4) @(negedge clock);
            push(m, 8'hC9);
            exp_q.push_back(8'h6D);
            frame(m, 8, 16'h006D, mi, 1'b1);
            chk("miso_c9", m, mi, 16'h00C9);
            chk("rx_6d", m, 16'(rx_data_v[m]), 16'h006D);
            chk("rx_q_drained", m, 16'(exp_q.size()), 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
